dphy_hs_lane_rx: RTL
====================

// Module: dphy_hs_lane_rx
// PURPOSE
//  Single-lane D-PHY HS receive front end in the dphy_clk domain. Takes the 2-bit DDR samples from
//  the lane SB_IO, tracks LP/HS state, hunts for the HS sync byte 0xB8 at either bit parity, then
//  emits aligned payload bytes with a 1-cycle strobe every 4 dphy_clk cycles. Sits between the lane
//  IO buffer and the word_clk-domain word combiner; the combiner samples byte_out via byte_valid.
// PARAMETERS
//  INVERT        1'b0  invert both din bits (lane P/N pair swapped on the board)
//  HS_SETTLE     8'd4  dphy_clk cycles ignored after LP->HS before sync hunting starts
//  SYNC_TIMEOUT  16'd1024  dphy_clk cycles in HUNT without sync before sync_err
// PORTS
//  dphy_clk      in   1  DDR bit clock from the clock lane (global buffer)
//  areset        in   1  asynchronous, active-high reset
//  din           in   2  DDR samples; din[0]=rising-edge bit (earlier), din[1]=falling-edge bit
//  lp_mode       in   1  asynchronous LP-state indicator (1 = lane in LP), synchronised internally
//  packet_done   in   1  1-cycle pulse (dphy_clk domain) from downstream: end of packet reached
//  byte_out      out  8  aligned payload byte, LSB = first bit received; held between strobes
//  byte_valid    out  1  1-cycle strobe, byte_out valid this cycle
//  sync_found    out  1  1-cycle pulse on sync byte detection
//  sync_err      out  1  HUNT timed out; held until next LP entry
//  bit_offset    out  1  locked parity: 0 = sync matched at sr[15:8], 1 = at sr[14:7]
//  state_dbg     out  2  current FSM state encoding
// BEHAVIOUR
//  - Reset (areset high, async): state=LP, sr=0, byte_out=0, byte_valid=0, sync_found=0, sync_err=0,
//    bit_offset=0, phase=0, settle/timeout counters=0, lp synchroniser flops=1.
//  - d = INVERT ? ~din : din. Shift each cycle: sr[15:0] <= {d[1], d[0], sr[15:2]} (LSB-first).
//  - lp_s = 2-flop synchronised lp_mode; 2-cycle latency.
//  - FSM (state_dbg): LP=0, HUNT=1, LOCKED=2, WAIT_LP=3.
//    LP: settle counter held 0; when lp_s==0 count up; at count==HS_SETTLE-1 -> HUNT, timeout cnt=0.
//    HUNT: match0 = (sr[15:8]==8'hB8), match1 = (sr[14:7]==8'hB8). On match: -> LOCKED,
//      bit_offset=match0?0:1 (match0 wins if both), sync_found=1 for one cycle, phase=0.
//      No match: timeout cnt++; at SYNC_TIMEOUT-1 -> WAIT_LP, sync_err=1.
//    LOCKED: phase counts 0..3 wrapping. On phase==3: byte_out <= bit_offset ? sr[14:7] : sr[15:8],
//      byte_valid=1 next cycle. First byte_valid 4 cycles after sync_found (bytes back-to-back,
//      exactly one strobe per 4 cycles). packet_done -> WAIT_LP, no further strobes.
//    WAIT_LP: no strobes; waits for lp_s==1 -> LP.
//  - lp_s==1 in any state -> LP next cycle, byte_valid forced 0 that cycle; LP has priority over
//    packet_done, sync match and timeout in the same cycle. Entering LP clears sync_err.
//  - packet_done coinciding with phase==3 in LOCKED: that byte is not strobed.
//  - packet_done outside LOCKED is ignored. The sync byte is never output.
//  - Counters saturate/clear only as stated; no wrap of timeout counter (state exits first).
//  - areset mid-packet: immediate return to reset values; requires LP->HS again to relock.
// TESTING
//  1 Reset, lp_mode=1 then 0, HS-zero then 0xB8 even parity, bytes 0x11,0x22 -> sync_found once,
//    bit_offset=0, byte_valid at +4,+8 cycles with byte_out 0x11,0x22.
//  2 Same with a one-bit prefix (odd parity) -> bit_offset=1, identical byte stream.
//  3 HS with no sync for SYNC_TIMEOUT cycles -> sync_err=1, state_dbg=3; lp_mode=1 -> sync_err=0, LP.
//  4 LOCKED, packet_done pulse -> strobes stop, state_dbg=3; a later 0xB8 in data is not relocked.
//  5 lp_mode asserted mid-byte with packet_done same cycle -> LP within 3 cycles, no further strobe.
//  6 INVERT=1 with inverted stimulus of test 1 -> identical byte_out sequence.

Source files
------------

// File: rtl/dphy_hs_lane_rx.sv
// Single-lane D-PHY HS receive front end: LP/HS tracking, 0xB8 sync hunt at
// either bit parity, then one aligned payload byte strobe every 4 dphy_clk cycles.
module dphy_hs_lane_rx #(
  parameter logic        INVERT       = 1'b0,
  parameter logic [7:0]  HS_SETTLE    = 8'd4,
  parameter logic [15:0] SYNC_TIMEOUT = 16'd1024
) (
  input  logic       dphy_clk,
  input  logic       areset,
  input  logic [1:0] din,
  input  logic       lp_mode,
  input  logic       packet_done,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       sync_found,
  output logic       sync_err,
  output logic       bit_offset,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_LP      = 2'd0,
    ST_HUNT    = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_WAIT_LP = 2'd3
  } state_t;

  state_t      state;
  logic [1:0]  d;
  // Only sr[15:7] of the LSB-first shift register is ever observed, so the
  // lower bits are not stored.
  logic [15:7] sr;
  logic        lp_meta;
  logic        lp_s;
  logic [7:0]  settle_cnt;
  logic [15:0] timeout_cnt;
  logic [1:0]  phase;
  logic        match0;
  logic        match1;

  assign d         = INVERT ? ~din : din;
  assign match0    = (sr[15:8] == 8'hB8);
  assign match1    = (sr[14:7] == 8'hB8);
  assign state_dbg = state;

  always_ff @(posedge dphy_clk or posedge areset) begin
    if (areset) begin
      state       <= ST_LP;
      sr          <= '0;
      lp_meta     <= 1'b1;
      lp_s        <= 1'b1;
      settle_cnt  <= '0;
      timeout_cnt <= '0;
      phase       <= '0;
      byte_out    <= '0;
      byte_valid  <= 1'b0;
      sync_found  <= 1'b0;
      sync_err    <= 1'b0;
      bit_offset  <= 1'b0;
    end else begin
      sr         <= {d[1], d[0], sr[15:9]};
      lp_meta    <= lp_mode;
      lp_s       <= lp_meta;
      byte_valid <= 1'b0;
      sync_found <= 1'b0;

      if (lp_s) begin
        // LP entry outranks packet_done, sync match and timeout.
        state      <= ST_LP;
        settle_cnt <= '0;
        sync_err   <= 1'b0;
      end else begin
        case (state)
          ST_LP: begin
            if (settle_cnt == HS_SETTLE - 8'd1) begin
              state       <= ST_HUNT;
              settle_cnt  <= '0;
              timeout_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + 8'd1;
            end
          end
          ST_HUNT: begin
            if (match0 || match1) begin
              state      <= ST_LOCKED;
              bit_offset <= ~match0;
              sync_found <= 1'b1;
              phase      <= '0;
            end else if (timeout_cnt == SYNC_TIMEOUT - 16'd1) begin
              state    <= ST_WAIT_LP;
              sync_err <= 1'b1;
            end else begin
              timeout_cnt <= timeout_cnt + 16'd1;
            end
          end
          ST_LOCKED: begin
            if (packet_done) begin
              state <= ST_WAIT_LP;
            end else begin
              phase <= phase + 2'd1;
              if (phase == 2'd3) begin
                byte_out   <= bit_offset ? sr[14:7] : sr[15:8];
                byte_valid <= 1'b1;
              end
            end
          end
          ST_WAIT_LP: begin
            state <= ST_WAIT_LP;
          end
          default: state <= ST_LP;
        endcase
      end
    end
  end

endmodule
